hilo_mdu: RTL and testbench
===========================

Name: hilo_mdu

Overview:
Multiply/divide unit in the EX stage. It produces the HI/LO write-enable and write-data pulses that the write-back HI/LO register pair consumes. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and raises a stall request while a multi-cycle operation is in flight. It is the writer side of the HI/LO write interface.

Parameters:
DIV_STEPS, 32, radix-2 restoring divide iterations; fixed at operand width.

Ports:
clock  input  1  system clock; all state on rising edge
reset  input  1  synchronous, active-low (0 = reset)
start  input  1  launch op this cycle; sampled only in IDLE
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; others are NOP
operand_a  input  32  rs value (dividend / multiplicand / MTHI/MTLO source)
operand_b  input  32  rt value (divisor / multiplier)
cancel  input  1  pipeline flush; aborts in-flight op
busy  output  1  registered; high while state != IDLE
stall_request  output  1  combinational; busy OR (start AND op in {DIV, DIVU} AND state == IDLE)
reg_hi_write_enable  output  1  one-cycle pulse
reg_hi_write_data  output  32  HI result
reg_lo_write_enable  output  1  one-cycle pulse
reg_lo_write_data  output  32  LO result

Behaviour:
- Reset (reset == 0 at rising edge):
  - state = IDLE, busy = 0, both write enables = 0, both write data = 0, divider registers = 0.
  - Reset overrides start, cancel and any in-flight operation.
- Outputs are registered. Write enables are high for exactly one cycle per completed op. Write data holds its last value when enable is 0.
- State machine: IDLE, MUL, DIV_RUN, DIV_FIX.
- IDLE:
  - start with MTHI: HI pulse with data = operand_a after the next edge (latency 1). LO is untouched. State stays IDLE.
  - start with MTLO: symmetric to MTHI on LO.
  - start with MULT/MULTU: latch operands, go to MUL.
  - start with DIV/DIVU: latch absolute values (DIV) or raw values (DIVU) plus sign flags, clear the step counter, go to DIV_RUN.
  - start with a NOP code: ignored.
- MUL: 64-bit product (signed for MULT, unsigned for MULTU); HI = [63:32], LO = [31:0]. Both enables pulse together after the edge leaving MUL. Latency 2 edges after start. Returns to IDLE.
- DIV_RUN: one restoring step per cycle; counter 0..31. At counter == 31, go to DIV_FIX.
- DIV_FIX: apply sign correction.
  - Quotient is negated if sign_a XOR sign_b.
  - Remainder takes the sign of the dividend.
  - HI = remainder, LO = quotient; both pulse.
  - Total latency 34 edges after start. Returns to IDLE.
- Divide by zero (operand_b == 0, signed or unsigned): skip iteration and go to DIV_FIX on the next edge. Result LO = 32'hFFFFFFFF, HI = operand_a. Latency 2.
- Signed overflow 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0 (falls out of the normal path; must be verified).
- start while busy: ignored. Upstream holds the instruction via stall_request.
- cancel:
  - When high at an edge with state != IDLE: state = IDLE, no write pulse that cycle or afterward.
  - cancel beats completion in the same cycle.
  - cancel in IDLE suppresses a same-cycle start, including MTHI/MTLO.
- busy rises the cycle after an accepted MULT/DIV start. It falls in the same cycle the write pulses become visible.

Decomposition:
- Shared package/defines file:
  - op encodings (MDU_OP_MULT … MDU_OP_MTLO).
  - state encodings.
  - RESET_ENABLE (1'b0) and WRITE_ENABLE (1'b1) macros, reused by the WB stage.
- One natural sub-module: mdu_divider, holding the iterative restoring core with the counter, partial remainder and quotient shift registers, plus start/cancel/done handshake.
- The multiply stays inline.

Test Plan:
- Reset held low 3 cycles mid-DIV, then released -> busy = 0, enables = 0, data = 0; the next start is accepted normally.
- MTHI with a = 32'hDEADBEEF -> one cycle later hi_we = 1, hi_data = 32'hDEADBEEF, lo_we = 0; no stall.
- MULT a = 32'hFFFFFFFE (-2), b = 3 -> 2 edges later hi = 32'hFFFFFFFF, lo = 32'hFFFFFFFA. MULTU with the same operands -> hi = 32'h00000002, lo = 32'hFFFFFFFA.
- DIV a = -7 (32'hFFFFFFF9), b = 2 -> stall_request high 34 cycles; lo = 32'hFFFFFFFD, hi = 32'hFFFFFFFF, both pulsing once. DIVU 100/7 -> lo = 14, hi = 2.
- DIVU a = 5, b = 0 -> 2 edges later lo = 32'hFFFFFFFF, hi = 5. DIV 32'h80000000 / -1 -> lo = 32'h80000000, hi = 0.
- DIV started, cancel pulsed at cycle 10, with a second start asserted during the busy window -> no write pulse ever, busy drops the next cycle, the second start is ignored; a fresh DIV after that completes correctly.

Source files
------------

// File: rtl/hilo_mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit and the WB-stage HI/LO register pair.
package hilo_mdu_pkg;

    localparam logic [2:0] MDU_OP_MULT  = 3'd0;
    localparam logic [2:0] MDU_OP_MULTU = 3'd1;
    localparam logic [2:0] MDU_OP_DIV   = 3'd2;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

    localparam logic [1:0] MDU_STATE_IDLE    = 2'd0;
    localparam logic [1:0] MDU_STATE_MUL     = 2'd1;
    localparam logic [1:0] MDU_STATE_DIV_RUN = 2'd2;
    localparam logic [1:0] MDU_STATE_DIV_FIX = 2'd3;

    localparam logic RESET_ENABLE = 1'b0;
    localparam logic WRITE_ENABLE = 1'b1;

    function automatic logic [31:0] negate_if(input logic neg, input logic [31:0] value);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative radix-2 restoring divider; one step per cycle, sign-corrected results held
// after done until the next start.
module mdu_divider
    import hilo_mdu_pkg::*;
#(
    parameter int unsigned DIV_STEPS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        cancel,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

    logic        running_q;
    logic [4:0]  count_q;
    logic [31:0] rem_q;
    logic [31:0] quot_q;
    logic [31:0] divisor_q;
    logic        sign_a_q;
    logic        sign_b_q;
    logic        zero_q;

    logic        sign_a;
    logic        sign_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] partial;
    logic [32:0] diff;

    always_comb begin
        sign_a  = is_signed & dividend[31];
        sign_b  = is_signed & divisor[31];
        abs_a   = negate_if(sign_a, dividend);
        abs_b   = negate_if(sign_b, divisor);
        partial = {rem_q, quot_q[31]};
        diff    = partial - {1'b0, divisor_q};
    end

    always_ff @(posedge clock) begin
        if (reset == RESET_ENABLE) begin
            running_q <= 1'b0;
            count_q   <= 5'd0;
            rem_q     <= 32'd0;
            quot_q    <= 32'd0;
            divisor_q <= 32'd0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            zero_q    <= 1'b0;
        end else if (start) begin
            // A zero divisor skips iteration; the dividend magnitude parks in the remainder
            // so the usual sign fix-up reproduces the raw dividend for HI.
            running_q <= (divisor != 32'd0);
            zero_q    <= (divisor == 32'd0);
            count_q   <= 5'd0;
            rem_q     <= (divisor == 32'd0) ? abs_a : 32'd0;
            quot_q    <= abs_a;
            divisor_q <= abs_b;
            sign_a_q  <= sign_a;
            sign_b_q  <= sign_b;
        end else if (cancel) begin
            running_q <= 1'b0;
        end else if (running_q) begin
            if (!diff[32]) begin
                rem_q  <= diff[31:0];
                quot_q <= {quot_q[30:0], 1'b1};
            end else begin
                rem_q  <= partial[31:0];
                quot_q <= {quot_q[30:0], 1'b0};
            end
            count_q <= count_q + 5'd1;
            if (count_q == LAST_STEP) begin
                running_q <= 1'b0;
            end
        end
    end

    assign done      = running_q & (count_q == LAST_STEP);
    assign quotient  = zero_q ? 32'hFFFF_FFFF : negate_if(sign_a_q ^ sign_b_q, quot_q);
    assign remainder = negate_if(sign_a_q, rem_q);

endmodule

// File: rtl/hilo_mdu.sv
// EX-stage multiply/divide unit driving the HI/LO write interface with one-cycle pulses.
module hilo_mdu
    import hilo_mdu_pkg::*;
#(
    parameter int unsigned DIV_STEPS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        cancel,
    output logic        busy,
    output logic        stall_request,
    output logic        reg_hi_write_enable,
    output logic [31:0] reg_hi_write_data,
    output logic        reg_lo_write_enable,
    output logic [31:0] reg_lo_write_data
);

    logic [1:0]  state_q, state_d;
    logic        hi_we_q, hi_we_d;
    logic        lo_we_q, lo_we_d;
    logic [31:0] hi_data_q, hi_data_d;
    logic [31:0] lo_data_q, lo_data_d;
    logic [31:0] mul_a_q;
    logic [31:0] mul_b_q;
    logic        mul_signed_q;

    logic        idle;
    logic        accept;
    logic        is_div_op;
    logic        is_mul_op;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic [63:0] mul_ext_a;
    logic [63:0] mul_ext_b;
    logic [63:0] mul_product;

    assign idle      = (state_q == MDU_STATE_IDLE);
    assign is_div_op = (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    assign is_mul_op = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
    // A cancel in IDLE kills a same-cycle start of any kind.
    assign accept    = start & idle & ~cancel;
    assign div_start = accept & is_div_op;

    // Low 64 bits of the extended product are correct for both signed and unsigned.
    assign mul_ext_a   = {{32{mul_signed_q & mul_a_q[31]}}, mul_a_q};
    assign mul_ext_b   = {{32{mul_signed_q & mul_b_q[31]}}, mul_b_q};
    assign mul_product = mul_ext_a * mul_ext_b;

    mdu_divider #(
        .DIV_STEPS (DIV_STEPS)
    ) u_divider (
        .clock     (clock),
        .reset     (reset),
        .start     (div_start),
        .cancel    (cancel),
        .is_signed (op == MDU_OP_DIV),
        .dividend  (operand_a),
        .divisor   (operand_b),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    always_comb begin
        state_d   = state_q;
        hi_we_d   = ~WRITE_ENABLE;
        lo_we_d   = ~WRITE_ENABLE;
        hi_data_d = hi_data_q;
        lo_data_d = lo_data_q;
        unique case (state_q)
            MDU_STATE_IDLE: begin
                if (accept) begin
                    case (op)
                        MDU_OP_MTHI: begin
                            hi_we_d   = WRITE_ENABLE;
                            hi_data_d = operand_a;
                        end
                        MDU_OP_MTLO: begin
                            lo_we_d   = WRITE_ENABLE;
                            lo_data_d = operand_a;
                        end
                        MDU_OP_MULT, MDU_OP_MULTU: state_d = MDU_STATE_MUL;
                        MDU_OP_DIV, MDU_OP_DIVU: begin
                            state_d = (operand_b == 32'd0) ? MDU_STATE_DIV_FIX
                                                           : MDU_STATE_DIV_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            MDU_STATE_MUL: begin
                hi_we_d   = WRITE_ENABLE;
                lo_we_d   = WRITE_ENABLE;
                hi_data_d = mul_product[63:32];
                lo_data_d = mul_product[31:0];
                state_d   = MDU_STATE_IDLE;
            end
            MDU_STATE_DIV_RUN: begin
                if (div_done) begin
                    state_d = MDU_STATE_DIV_FIX;
                end
            end
            MDU_STATE_DIV_FIX: begin
                hi_we_d   = WRITE_ENABLE;
                lo_we_d   = WRITE_ENABLE;
                hi_data_d = div_remainder;
                lo_data_d = div_quotient;
                state_d   = MDU_STATE_IDLE;
            end
        endcase
        if (cancel && !idle) begin
            state_d   = MDU_STATE_IDLE;
            hi_we_d   = ~WRITE_ENABLE;
            lo_we_d   = ~WRITE_ENABLE;
            hi_data_d = hi_data_q;
            lo_data_d = lo_data_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset == RESET_ENABLE) begin
            state_q      <= MDU_STATE_IDLE;
            hi_we_q      <= 1'b0;
            lo_we_q      <= 1'b0;
            hi_data_q    <= 32'd0;
            lo_data_q    <= 32'd0;
            mul_a_q      <= 32'd0;
            mul_b_q      <= 32'd0;
            mul_signed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_we_q   <= hi_we_d;
            lo_we_q   <= lo_we_d;
            hi_data_q <= hi_data_d;
            lo_data_q <= lo_data_d;
            if (accept && is_mul_op) begin
                mul_a_q      <= operand_a;
                mul_b_q      <= operand_b;
                mul_signed_q <= (op == MDU_OP_MULT);
            end
        end
    end

    assign busy                = ~idle;
    assign stall_request       = busy | (start & is_div_op & idle);
    assign reg_hi_write_enable = hi_we_q;
    assign reg_hi_write_data   = hi_data_q;
    assign reg_lo_write_enable = lo_we_q;
    assign reg_lo_write_data   = lo_data_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu: results, latency, stall window, cancel and reset behaviour.
module tb_hilo_mdu;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        cancel;
    logic        busy;
    logic        stall_request;
    logic        hi_we;
    logic [31:0] hi_data;
    logic        lo_we;
    logic [31:0] lo_data;

    int tests_run;
    int tests_failed;

    hilo_mdu dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .op                  (op),
        .operand_a           (operand_a),
        .operand_b           (operand_b),
        .cancel              (cancel),
        .busy                (busy),
        .stall_request       (stall_request),
        .reg_hi_write_enable (hi_we),
        .reg_hi_write_data   (hi_data),
        .reg_lo_write_enable (lo_we),
        .reg_lo_write_data   (lo_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Launches one op and waits for the write pulse; lat counts edges including the start edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stalls);
        stalls    = 0;
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        #1;
        if (stall_request) stalls++;
        step();
        start = 1'b0;
        lat   = 1;
        while (!(hi_we || lo_we) && lat < 60) begin
            if (stall_request) stalls++;
            step();
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] b, input int exp_lat,
                                input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        int stalls;
        run_op(o, a, b, lat, stalls);
        check_value({tag, " latency"}, lat, exp_lat);
        check_value({tag, " hi_we"}, {31'd0, hi_we}, 32'd1);
        check_value({tag, " lo_we"}, {31'd0, lo_we}, 32'd1);
        check_value({tag, " hi"}, hi_data, exp_hi);
        check_value({tag, " lo"}, lo_data, exp_lo);
        check_value({tag, " busy at pulse"}, {31'd0, busy}, 32'd0);
        if (o == 3'd2 || o == 3'd3) begin
            check_value({tag, " stall cycles"}, stalls, (exp_lat == 34) ? 34 : 2);
        end
        step();
        check_value({tag, " single pulse"}, {30'd0, hi_we, lo_we}, 32'd0);
        check_value({tag, " hi held"}, hi_data, exp_hi);
    endtask

    initial begin
        int lat;
        int stalls;
        int pulses;
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b0;
        start     = 1'b0;
        op        = 3'd0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        cancel    = 1'b0;
        repeat (3) step();
        check_value("reset busy", {31'd0, busy}, 32'd0);
        check_value("reset enables", {30'd0, hi_we, lo_we}, 32'd0);
        check_value("reset hi", hi_data, 32'd0);
        check_value("reset lo", lo_data, 32'd0);
        reset = 1'b1;
        step();

        // MTHI: latency 1, LO untouched, no stall.
        run_op(3'd4, 32'hDEAD_BEEF, 32'd0, lat, stalls);
        check_value("mthi latency", lat, 1);
        check_value("mthi hi_we", {31'd0, hi_we}, 32'd1);
        check_value("mthi lo_we", {31'd0, lo_we}, 32'd0);
        check_value("mthi hi", hi_data, 32'hDEAD_BEEF);
        check_value("mthi stalls", stalls, 0);
        check_value("mthi busy", {31'd0, busy}, 32'd0);
        step();
        check_value("mthi single pulse", {31'd0, hi_we}, 32'd0);

        run_op(3'd5, 32'h1234_5678, 32'd0, lat, stalls);
        check_value("mtlo latency", lat, 1);
        check_value("mtlo lo_we", {31'd0, lo_we}, 32'd1);
        check_value("mtlo hi_we", {31'd0, hi_we}, 32'd0);
        check_value("mtlo lo", lo_data, 32'h1234_5678);
        check_value("mtlo hi held", hi_data, 32'hDEAD_BEEF);
        step();

        check_result("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        check_result("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 2, 32'h0000_0002, 32'hFFFF_FFFA);
        check_result("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check_result("div 7/-2", 3'd2, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD);
        check_result("divu 100/7", 3'd3, 32'd100, 32'd7, 34, 32'd2, 32'd14);
        check_result("divu 5/0", 3'd3, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF);
        check_result("div -9/0", 3'd2, 32'hFFFF_FFF7, 32'd0, 2, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
        check_result("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000);

        // NOP encoding: nothing happens.
        start = 1'b1;
        op    = 3'd6;
        step();
        start  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (hi_we || lo_we || busy) pulses++;
            step();
        end
        check_value("nop ignored", pulses, 0);

        // Cancel mid-divide with a second start during the busy window.
        start     = 1'b1;
        op        = 3'd2;
        operand_a = 32'd100;
        operand_b = 32'd7;
        step();
        start  = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 50; i++) begin
            if (i == 5) begin
                start     = 1'b1;
                op        = 3'd4;
                operand_a = 32'h1111_1111;
            end
            if (i == 7) start = 1'b0;
            if (i == 10) cancel = 1'b1;
            step();
            if (hi_we || lo_we) pulses++;
            if (i == 10) begin
                cancel = 1'b0;
                check_value("cancel busy drop", {31'd0, busy}, 32'd0);
            end
        end
        check_value("cancel no pulse", pulses, 0);
        check_value("cancel hi held", hi_data, 32'd0);
        check_value("cancel lo held", lo_data, 32'h8000_0000);

        // Cancel in IDLE suppresses a same-cycle MTHI.
        start     = 1'b1;
        cancel    = 1'b1;
        op        = 3'd4;
        operand_a = 32'h2222_2222;
        step();
        start  = 1'b0;
        cancel = 1'b0;
        check_value("idle cancel hi_we", {31'd0, hi_we}, 32'd0);
        check_value("idle cancel hi", hi_data, 32'd0);

        check_result("div 100/-7", 3'd2, 32'd100, 32'hFFFF_FFF9, 34, 32'd2, 32'hFFFF_FFF2);

        // Reset held low three cycles in the middle of a divide.
        start     = 1'b1;
        op        = 3'd3;
        operand_a = 32'd1000;
        operand_b = 32'd3;
        step();
        start = 1'b0;
        repeat (5) step();
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        check_value("mid reset busy", {31'd0, busy}, 32'd0);
        check_value("mid reset enables", {30'd0, hi_we, lo_we}, 32'd0);
        check_value("mid reset hi", hi_data, 32'd0);
        check_value("mid reset lo", lo_data, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (hi_we || lo_we || busy) pulses++;
        end
        check_value("mid reset quiet", pulses, 0);
        check_result("multu after reset", 3'd1, 32'd7, 32'd6, 2, 32'd0, 32'd42);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
